// File: rtl/z80_sound_mailbox_pkg.sv
// Shared constants for the 68K->Z80 sound command path.
// Z80 port numbers are shared with the chip select decode.
package tc_sound_pkg;

    localparam int unsigned IRQ_DIV_DEF   = 512;
    localparam logic [7:0]  CLR_VALUE_DEF = 8'h00;
    localparam logic [7:0]  IDLE_DATA_DEF = 8'hFF;

    localparam logic [7:0]  Z80_PORT_LATCH_CLR = 8'h04;
    localparam logic [7:0]  Z80_PORT_LATCH_RD  = 8'h06;

    typedef struct packed {
        logic wr;
        logic clr;
    } latch_strobe_t;

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/z80_sound_mailbox_periodic_irq_gen.sv
// Periodic Z80 interrupt: divides z80_cen, holds INT low until acknowledged,
// and flags a tick that lands while the previous IRQ is still pending.
module periodic_irq_gen
    import tc_sound_pkg::*;
#(
    parameter int unsigned IRQ_DIV = IRQ_DIV_DEF
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic z80_cen,
    input  logic irq_enable,
    input  logic irq_ack,
    output logic z80_irq_n,
    output logic irq_overrun
);

    localparam int unsigned    CntW   = cnt_width(IRQ_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(IRQ_DIV - 1);

    logic [CntW-1:0] r_cnt;
    logic            r_irq_n;
    logic            r_overrun;
    logic            w_adv;
    logic            w_tick;

    assign w_adv  = z80_cen & irq_enable;
    assign w_tick = w_adv & (r_cnt == CntMax);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_irq_n   <= 1'b1;
            r_overrun <= 1'b0;
        end else begin
            if (w_adv) begin
                r_cnt <= w_tick ? '0 : r_cnt + CntW'(1);
            end
            // A tick beats a same-edge acknowledge; that case is not an overrun.
            if (w_tick) begin
                r_irq_n <= 1'b0;
                if (!r_irq_n && !irq_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (irq_ack) begin
                r_irq_n <= 1'b1;
            end
        end
    end

    assign z80_irq_n   = r_irq_n;
    assign irq_overrun = r_overrun;

endmodule

// File: rtl/z80_sound_mailbox.sv
// Z80 side of the sound command path: captures the 68K byte, serves it on the
// latch-read port, clears it on the latch-clear port and raises the periodic IRQ.
module z80_sound_mailbox
    import tc_sound_pkg::*;
#(
    parameter int unsigned IRQ_DIV   = IRQ_DIV_DEF,
    parameter logic [7:0]  CLR_VALUE = CLR_VALUE_DEF,
    parameter logic [7:0]  IDLE_DATA = IDLE_DATA_DEF
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       z80_cen,
    input  logic       sound_latch_cs,
    input  logic       cpu_lds_n,
    input  logic       cpu_rw,
    input  logic [7:0] cpu_dout,
    input  logic       z80_latch_clr_cs,
    input  logic       z80_latch_r_cs,
    input  logic       RD_n,
    input  logic       M1_n,
    input  logic       IORQ_n,
    input  logic       irq_enable,
    output logic [7:0] z80_latch_dout,
    output logic       z80_irq_n,
    output logic       latch_pending,
    output logic       irq_overrun
);

    latch_strobe_t w_strobe;
    latch_strobe_t r_strobe;
    logic          r_wr_armed;
    logic [7:0]    r_latch;
    logic          r_pending;
    logic          w_wr_rise;
    logic          w_clr_rise;
    logic          w_io_rd;
    logic          w_ack;

    assign w_io_rd      = ~IORQ_n & M1_n & ~RD_n;
    assign w_strobe.wr  = sound_latch_cs & ~cpu_lds_n & ~cpu_rw;
    assign w_strobe.clr = z80_latch_clr_cs & w_io_rd;
    assign w_ack        = ~M1_n & ~IORQ_n;

    // A strobe still held across reset must drop once before it can capture.
    assign w_wr_rise  = w_strobe.wr & ~r_strobe.wr & r_wr_armed;
    assign w_clr_rise = w_strobe.clr & ~r_strobe.clr;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_strobe   <= '0;
            r_wr_armed <= 1'b0;
            r_latch    <= CLR_VALUE;
            r_pending  <= 1'b0;
        end else begin
            r_strobe <= w_strobe;
            if (!w_strobe.wr) begin
                r_wr_armed <= 1'b1;
            end
            // Write wins over a same-edge clear so no command is lost.
            if (w_wr_rise) begin
                r_latch   <= cpu_dout;
                r_pending <= 1'b1;
            end else if (w_clr_rise) begin
                r_latch   <= CLR_VALUE;
                r_pending <= 1'b0;
            end
        end
    end

    assign z80_latch_dout = (z80_latch_r_cs & w_io_rd) ? r_latch : IDLE_DATA;
    assign latch_pending  = r_pending;

    periodic_irq_gen #(
        .IRQ_DIV(IRQ_DIV)
    ) u_irq_gen (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .z80_cen    (z80_cen),
        .irq_enable (irq_enable),
        .irq_ack    (w_ack),
        .z80_irq_n  (z80_irq_n),
        .irq_overrun(irq_overrun)
    );

endmodule

// File: tb/tb_z80_sound_mailbox.sv
// Self-checking bench: directed scenarios plus random bus traffic, all compared
// every cycle against a behavioural model of the mailbox and IRQ divider.
module tb_z80_sound_mailbox;

    localparam int unsigned IrqDiv = 512;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       z80_cen;
    logic       sound_latch_cs;
    logic       cpu_lds_n;
    logic       cpu_rw;
    logic [7:0] cpu_dout;
    logic       z80_latch_clr_cs;
    logic       z80_latch_r_cs;
    logic       RD_n;
    logic       M1_n;
    logic       IORQ_n;
    logic       irq_enable;
    logic [7:0] z80_latch_dout;
    logic       z80_irq_n;
    logic       latch_pending;
    logic       irq_overrun;

    z80_sound_mailbox u_dut (
        .clk_sys         (clk_sys),
        .reset_n         (reset_n),
        .z80_cen         (z80_cen),
        .sound_latch_cs  (sound_latch_cs),
        .cpu_lds_n       (cpu_lds_n),
        .cpu_rw          (cpu_rw),
        .cpu_dout        (cpu_dout),
        .z80_latch_clr_cs(z80_latch_clr_cs),
        .z80_latch_r_cs  (z80_latch_r_cs),
        .RD_n            (RD_n),
        .M1_n            (M1_n),
        .IORQ_n          (IORQ_n),
        .irq_enable      (irq_enable),
        .z80_latch_dout  (z80_latch_dout),
        .z80_irq_n       (z80_irq_n),
        .latch_pending   (latch_pending),
        .irq_overrun     (irq_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned cyc      = 0;

    // Model state: latched command, IRQ pending, total enabled cen pulses.
    logic [7:0]  m_latch = 8'h00;
    bit          m_pend, m_irq, m_ovr;
    bit          m_prev_wr, m_prev_clr, m_wr_seen_idle;
    int unsigned m_cens;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d, t=%0t)",
                     tag, got, exp, cyc, $time);
        end
    endtask

    function automatic void model_edge();
        bit wr, clr, ack, tick;
        if (!reset_n) begin
            m_latch = 8'h00; m_pend = 0; m_irq = 0; m_ovr = 0;
            m_prev_wr = 0; m_prev_clr = 0; m_wr_seen_idle = 0; m_cens = 0;
            return;
        end
        wr   = sound_latch_cs && !cpu_lds_n && !cpu_rw;
        clr  = z80_latch_clr_cs && !IORQ_n && M1_n && !RD_n;
        ack  = !M1_n && !IORQ_n;
        tick = 0;
        if (wr && !m_prev_wr && m_wr_seen_idle) begin
            m_latch = cpu_dout; m_pend = 1;
        end else if (clr && !m_prev_clr) begin
            m_latch = 8'h00; m_pend = 0;
        end
        if (!wr) m_wr_seen_idle = 1;
        m_prev_wr  = wr;
        m_prev_clr = clr;
        if (z80_cen && irq_enable) begin
            m_cens++;
            tick = (m_cens % IrqDiv) == 0;
        end
        if (tick) begin
            if (m_irq && !ack) m_ovr = 1;
            m_irq = 1;
        end else if (ack) begin
            m_irq = 0;
        end
    endfunction

    task automatic check_all();
        logic [7:0] exp_dout;
        exp_dout = (z80_latch_r_cs && !IORQ_n && M1_n && !RD_n) ? m_latch : 8'hFF;
        check_val("dout", z80_latch_dout, exp_dout);
        check_val("pending", latch_pending, m_pend);
        check_val("irq_n", z80_irq_n, !m_irq);
        check_val("overrun", irq_overrun, m_ovr);
    endtask

    task automatic tick_clk();
        @(posedge clk_sys);
        model_edge();
        cyc = reset_n ? cyc + 1 : 0;
        #1 check_all();
        @(negedge clk_sys);
    endtask

    task automatic irq_clk();
        z80_cen = (cyc % 4) == 3;
        tick_clk();
    endtask

    task automatic set_idle();
        sound_latch_cs = 0; cpu_lds_n = 1; cpu_rw = 1; cpu_dout = 8'h00;
        z80_latch_clr_cs = 0; z80_latch_r_cs = 0; RD_n = 1; M1_n = 1; IORQ_n = 1;
        z80_cen = 0; irq_enable = 1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick_clk();
        tick_clk();
        reset_n = 1;
    endtask

    task automatic set_read(input bit rd06);
        z80_latch_r_cs = rd06; z80_latch_clr_cs = !rd06;
        IORQ_n = 0; RD_n = 0; M1_n = 1;
    endtask

    task automatic end_io();
        z80_latch_r_cs = 0; z80_latch_clr_cs = 0; IORQ_n = 1; RD_n = 1;
    endtask

    initial begin
        set_idle();
        reset_n = 0;
        @(negedge clk_sys);
        do_reset();
        check_val("rst_pending", latch_pending, 0);
        check_val("rst_irq_n", z80_irq_n, 1);
        check_val("rst_overrun", irq_overrun, 0);
        check_val("rst_idle_dout", z80_latch_dout, 8'hFF);
        tick_clk();

        // Write 5A, strobe held 6 clocks, data changes after the first.
        sound_latch_cs = 1; cpu_lds_n = 0; cpu_rw = 0; cpu_dout = 8'h5A;
        tick_clk();
        cpu_dout = 8'h11;
        repeat (5) tick_clk();
        set_idle();
        tick_clk();
        check_val("t1_pending", latch_pending, 1);
        check_val("t1_idle_dout", z80_latch_dout, 8'hFF);
        set_read(1);
        tick_clk();
        check_val("t1_read06", z80_latch_dout, 8'h5A);
        end_io();
        tick_clk();

        // Clear via port 04 held 3 clocks, then a second clear, then read.
        set_read(0);
        repeat (3) tick_clk();
        end_io();
        tick_clk();
        check_val("t2_pending", latch_pending, 0);
        set_read(0);
        tick_clk();
        end_io();
        tick_clk();
        set_read(1);
        tick_clk();
        check_val("t2_read06", z80_latch_dout, 8'h00);
        end_io();
        tick_clk();

        // Write edge and clear edge on the same clock.
        sound_latch_cs = 1; cpu_lds_n = 0; cpu_rw = 0; cpu_dout = 8'h33;
        set_read(0);
        tick_clk();
        set_idle();
        tick_clk();
        check_val("t3_pending", latch_pending, 1);
        set_read(1);
        tick_clk();
        check_val("t3_read06", z80_latch_dout, 8'h33);
        set_idle();
        tick_clk();

        // Upper-byte-only write and 68K read are ignored.
        set_read(0);
        tick_clk();
        set_idle();
        sound_latch_cs = 1; cpu_lds_n = 1; cpu_rw = 0; cpu_dout = 8'h77;
        tick_clk();
        cpu_lds_n = 0; cpu_rw = 1;
        tick_clk();
        set_idle();
        tick_clk();
        check_val("t_ignored_pending", latch_pending, 0);

        // Reset while the 68K strobe is held; no recapture until it toggles.
        sound_latch_cs = 1; cpu_lds_n = 0; cpu_rw = 0; cpu_dout = 8'hAA;
        tick_clk();
        do_reset();
        check_val("t6_rst_pending", latch_pending, 0);
        repeat (4) tick_clk();
        check_val("t6_held_pending", latch_pending, 0);
        cpu_lds_n = 1;
        tick_clk();
        cpu_lds_n = 0; cpu_dout = 8'hC3;
        tick_clk();
        check_val("t6_retoggle_pending", latch_pending, 1);
        set_idle();
        set_read(1);
        tick_clk();
        check_val("t6_read06", z80_latch_dout, 8'hC3);
        set_idle();

        // IRQ timing with cen every 4 clocks.
        do_reset();
        for (int i = 0; i < 3000 && z80_irq_n; i++) irq_clk();
        check_val("irq1_fall_cyc", cyc, 2048);
        M1_n = 0; IORQ_n = 0;
        irq_clk();
        M1_n = 1; IORQ_n = 1;
        check_val("irq_ack_release", z80_irq_n, 1);
        for (int i = 0; i < 3000 && z80_irq_n; i++) irq_clk();
        check_val("irq2_fall_cyc", cyc, 4096);
        for (int i = 0; i < 3000 && cyc < 6143; i++) irq_clk();
        check_val("ovr_before_3rd", irq_overrun, 0);
        irq_clk();
        check_val("ovr_at_3rd", irq_overrun, 1);
        check_val("irq_held_low", z80_irq_n, 0);
        M1_n = 0; IORQ_n = 0;
        irq_clk();
        M1_n = 1; IORQ_n = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!z80_irq_n) break;
            irq_enable = !(cyc >= 6148 && cyc < 6548);
            irq_clk();
        end
        irq_enable = 1;
        check_val("irq_freeze_fall_cyc", cyc, 8592);
        check_val("ovr_sticky", irq_overrun, 1);

        // Random bus traffic with occasional resets.
        set_idle();
        for (int i = 0; i < 6000; i++) begin
            reset_n          = ($urandom_range(799) != 0);
            sound_latch_cs   = ($urandom_range(3) == 0);
            cpu_lds_n        = ($urandom_range(3) == 0);
            cpu_rw           = ($urandom_range(3) == 0);
            cpu_dout         = 8'($urandom);
            z80_latch_clr_cs = ($urandom_range(5) == 0);
            z80_latch_r_cs   = ($urandom_range(2) == 0);
            RD_n             = ($urandom_range(2) == 0);
            IORQ_n           = ($urandom_range(1) == 0);
            M1_n             = ($urandom_range(39) != 0);
            z80_cen          = ($urandom_range(3) == 0);
            irq_enable       = ($urandom_range(9) != 0);
            tick_clk();
        end
        reset_n = 1;
        set_idle();
        tick_clk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
